// File: rtl/alu_sequencer.sv
// alu_sequencer: accumulator-based control stage for a 4-bit bit-sliced ALU.
// Sequences settle/capture passes and hands results back over valid/ready.
module alu_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       InValid,
  output logic       InReady,
  input  logic [2:0] InOp,
  input  logic [3:0] InOperand,
  input  logic [1:0] InCount,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       ModeShift,
  output logic       ModeAdder,
  output logic       SEL1,
  output logic       SEL0,
  input  logic [3:0] S,
  input  logic       CarryOut,
  output logic       ResValid,
  input  logic       ResReady,
  output logic [3:0] Result,
  output logic       Carry,
  output logic       Zero
);

  localparam logic [2:0] SETTLE = 3'(SETTLE_CYCLES);

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_NOT  = 3'b001;
  localparam logic [2:0] OP_NOR  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_e;

  state_e     state_q;
  logic [2:0] op_q;
  logic [3:0] acc_q;
  logic [3:0] b_q;
  logic       carry_q;
  logic [2:0] wait_q;
  logic [1:0] pass_q;
  logic [1:0] sel_q;
  logic       shift_q;
  logic       adder_q;
  logic       valid_q;

  logic [3:0] ctrl_d;
  logic       carry_d;
  logic       in_shift;

  // {SEL1, SEL0, ModeShift, ModeAdder} for the incoming op
  always_comb begin
    ctrl_d = 4'b0000;
    case (InOp)
      OP_NOR:  ctrl_d = 4'b0100;
      OP_SHL:  ctrl_d = 4'b1010;
      OP_SHR:  ctrl_d = 4'b1000;
      OP_ADD:  ctrl_d = 4'b1100;
      OP_SUB:  ctrl_d = 4'b1101;
      default: ctrl_d = 4'b0000;
    endcase
  end

  assign in_shift = (InOp == OP_SHL) || (InOp == OP_SHR);

  // shifts report the bit leaving the pre-pass accumulator
  always_comb begin
    carry_d = 1'b0;
    unique case (1'b1)
      (op_q == OP_ADD) || (op_q == OP_SUB): carry_d = CarryOut;
      (op_q == OP_SHL):                     carry_d = acc_q[3];
      (op_q == OP_SHR):                     carry_d = acc_q[0];
      default:                              carry_d = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      acc_q   <= 4'd0;
      b_q     <= 4'd0;
      carry_q <= 1'b0;
      wait_q  <= 3'd0;
      pass_q  <= 2'd0;
      sel_q   <= 2'd0;
      shift_q <= 1'b0;
      adder_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (InValid) begin
            op_q    <= InOp;
            b_q     <= InOperand;
            sel_q   <= ctrl_d[3:2];
            shift_q <= ctrl_d[1];
            adder_q <= ctrl_d[0];
            if (InOp == OP_LOAD || InOp == OP_NOP) begin
              if (InOp == OP_LOAD) acc_q <= InOperand;
              carry_q <= 1'b0;
              valid_q <= 1'b1;
              state_q <= S_DONE;
            end else begin
              wait_q  <= SETTLE;
              pass_q  <= in_shift ? InCount : 2'd0;
              state_q <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (wait_q != 3'd0) begin
            wait_q <= wait_q - 3'd1;
          end else begin
            acc_q   <= S;
            carry_q <= carry_d;
            if (pass_q != 2'd0) begin
              pass_q <= pass_q - 2'd1;
              wait_q <= SETTLE;
            end else begin
              valid_q <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (ResReady) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign InReady   = (state_q == S_IDLE);
  assign A         = acc_q;
  assign B         = b_q;
  assign SEL1      = sel_q[1];
  assign SEL0      = sel_q[0];
  assign ModeShift = shift_q;
  assign ModeAdder = adder_q;
  assign ResValid  = valid_q;
  assign Result    = acc_q;
  assign Carry     = carry_q;
  assign Zero      = (acc_q == 4'd0);

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: drives alu_sequencer against a behavioural ALU stand-in
// and an arithmetic reference model of each instruction.
module tb_alu_sequencer;

  localparam int SETTLE = 1;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_NOT  = 3'b001;
  localparam logic [2:0] OP_NOR  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  logic       Clk;
  logic       nReset;
  logic       InValid;
  logic       InReady;
  logic [2:0] InOp;
  logic [3:0] InOperand;
  logic [1:0] InCount;
  logic [3:0] A;
  logic [3:0] B;
  logic       ModeShift;
  logic       ModeAdder;
  logic       SEL1;
  logic       SEL0;
  logic [3:0] S;
  logic       CarryOut;
  logic       ResValid;
  logic       ResReady;
  logic [3:0] Result;
  logic       Carry;
  logic       Zero;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] m_acc = 4'd0;

  alu_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .Clk(Clk), .nReset(nReset),
    .InValid(InValid), .InReady(InReady),
    .InOp(InOp), .InOperand(InOperand), .InCount(InCount),
    .A(A), .B(B),
    .ModeShift(ModeShift), .ModeAdder(ModeAdder),
    .SEL1(SEL1), .SEL0(SEL0),
    .S(S), .CarryOut(CarryOut),
    .ResValid(ResValid), .ResReady(ResReady),
    .Result(Result), .Carry(Carry), .Zero(Zero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // bit-sliced ALU stand-in
  always_comb begin
    S = 4'd0;
    CarryOut = 1'b0;
    case ({SEL1, SEL0})
      2'b00: S = ~A;
      2'b01: S = ~(A | B);
      2'b10: S = ModeShift ? {A[2:0], 1'b0} : {1'b0, A[3:1]};
      default: begin
        if (ModeAdder) {CarryOut, S} = {1'b0, A} + {1'b0, ~B} + 5'd1;
        else           {CarryOut, S} = {1'b0, A} + {1'b0, B};
      end
    endcase
  end

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_shift(input logic [2:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

  function automatic logic [3:0] ctrl_of(input logic [2:0] op);
    case (op)
      OP_NOR:  return 4'b0100;
      OP_SHL:  return 4'b1010;
      OP_SHR:  return 4'b1000;
      OP_ADD:  return 4'b1100;
      OP_SUB:  return 4'b1101;
      default: return 4'b0000;
    endcase
  endfunction

  // {carry, result} after the given number of passes
  function automatic logic [4:0] ref_op(input logic [2:0] op,
      input logic [3:0] acc, input logic [3:0] b, input int passes);
    int v;
    bit c;
    v = int'(acc);
    c = 1'b0;
    case (op)
      OP_LOAD: v = int'(b);
      OP_NOT:  v = 15 - int'(acc);
      OP_NOR:  v = 15 - int'(acc | b);
      OP_ADD: begin
        v = int'(acc) + int'(b);
        c = (v > 15);
        v = v % 16;
      end
      OP_SUB: begin
        c = (acc >= b);
        v = (int'(acc) - int'(b) + 16) % 16;
      end
      OP_SHL:
        for (int i = 0; i < passes; i++) begin
          c = (v >= 8);
          v = (v * 2) % 16;
        end
      OP_SHR:
        for (int i = 0; i < passes; i++) begin
          c = (v % 2) == 1;
          v = v / 2;
        end
      default: v = int'(acc);
    endcase
    return {c, 4'(v)};
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [3:0] opnd,
                        input logic [1:0] cnt, input int hold);
    logic [4:0] exp;
    logic [4:0] mid;
    logic [3:0] pre;
    int lat;
    int total;
    int per;
    int passes;
    bit alu;
    int n;
    n = 0;
    while (!InReady && n < 20) begin
      @(negedge Clk);
      n++;
    end
    check("in_ready", 8'(InReady), 8'd1);
    pre = m_acc;
    alu = !(op == OP_LOAD || op == OP_NOP);
    per = SETTLE + 1;
    passes = is_shift(op) ? int'(cnt) + 1 : 1;
    total = alu ? passes * per : 0;
    exp = ref_op(op, pre, opnd, passes);
    InValid = 1'b1;
    InOp = op;
    InOperand = opnd;
    InCount = cnt;
    @(posedge Clk);
    #1;
    InValid = 1'b0;
    InOp = 3'($urandom);
    InOperand = 4'($urandom);
    InCount = 2'($urandom);
    @(negedge Clk);
    check("ctrl", 8'({SEL1, SEL0, ModeShift, ModeAdder}), 8'(ctrl_of(op)));
    check("b_reg", 8'(B), 8'(opnd));
    check("a_first", 8'(A), 8'(alu ? pre : exp[3:0]));
    lat = 0;
    while (!ResValid && lat < 64) begin
      @(posedge Clk);
      lat++;
      @(negedge Clk);
      if (is_shift(op) && (lat % per) == 0 && lat < total) begin
        mid = ref_op(op, pre, opnd, lat / per);
        check("a_pass", 8'(A), 8'(mid[3:0]));
      end
    end
    check("latency", 8'(lat), 8'(total));
    check("result", 8'(Result), 8'(exp[3:0]));
    check("carry", 8'(Carry), 8'(exp[4]));
    check("zero", 8'(Zero), 8'(exp[3:0] == 4'd0));
    check("busy", 8'(InReady), 8'd0);
    m_acc = exp[3:0];
    for (int h = 0; h < hold; h++) begin
      InValid = 1'b1;
      InOp = 3'($urandom);
      InOperand = 4'($urandom);
      @(posedge Clk);
      @(negedge Clk);
      check("hold_valid", 8'(ResValid), 8'd1);
      check("hold_result", 8'({Carry, Result}), 8'(exp));
    end
    InValid = 1'b0;
    ResReady = 1'b1;
    @(posedge Clk);
    #1;
    ResReady = 1'b0;
    @(negedge Clk);
    check("released", 8'({InReady, ResValid}), 8'b10);
  endtask

  task automatic reset_mid_exec();
    InValid = 1'b1;
    InOp = OP_ADD;
    InOperand = 4'd3;
    InCount = 2'd0;
    @(posedge Clk);
    #1;
    InValid = 1'b0;
    #2;
    nReset = 1'b0;
    #1;
    check("rst_valid", 8'(ResValid), 8'd0);
    check("rst_ready", 8'(InReady), 8'd1);
    check("rst_a", 8'(A), 8'd0);
    check("rst_ctrl", 8'({SEL1, SEL0, ModeShift, ModeAdder, Carry}), 8'd0);
    @(negedge Clk);
    nReset = 1'b1;
    m_acc = 4'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    nReset = 1'b0;
    InValid = 1'b0;
    InOp = OP_NOP;
    InOperand = 4'd0;
    InCount = 2'd0;
    ResReady = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset_ready", 8'({InReady, ResValid}), 8'b10);
    check("reset_ab", {A, B}, 8'd0);
    check("reset_ctrl", 8'({SEL1, SEL0, ModeShift, ModeAdder, Carry}), 8'd0);
    nReset = 1'b1;
    @(negedge Clk);

    run_op(OP_LOAD, 4'b0101, 2'd0, 0);
    run_op(OP_ADD,  4'b0011, 2'd0, 0);
    run_op(OP_ADD,  4'b1000, 2'd0, 0);
    run_op(OP_LOAD, 4'b0011, 2'd0, 0);
    run_op(OP_SUB,  4'b0101, 2'd0, 0);
    run_op(OP_LOAD, 4'b0101, 2'd0, 0);
    run_op(OP_SUB,  4'b0011, 2'd0, 0);
    run_op(OP_LOAD, 4'b1011, 2'd0, 0);
    run_op(OP_SHL,  4'b0000, 2'd1, 0);
    run_op(OP_LOAD, 4'b1001, 2'd0, 0);
    run_op(OP_SHR,  4'b0000, 2'd3, 5);
    run_op(OP_NOT,  4'b0000, 2'd0, 1);
    run_op(OP_NOR,  4'b0100, 2'd0, 0);
    run_op(OP_NOP,  4'b1111, 2'd2, 0);

    reset_mid_exec();
    run_op(OP_LOAD, 4'b0110, 2'd0, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom), 4'($urandom), 2'($urandom),
             int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
